// File: rtl/alu_pipe.sv
// Registered stack-machine ALU with a valid/ready handshake, a persistent carry flag
// and a multi-cycle nibble-contains (CON) window scan.
module alu_pipe #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NIB        = 4,
    parameter bit          SIGNED_CMP = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] reg_val,
    input  logic [WIDTH-1:0] stack0,
    input  logic [WIDTH-1:0] stack1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] reg_out,
    output logic [WIDTH-1:0] stack0_out,
    output logic [WIDTH-1:0] stack1_out,
    output logic             branch_sig,
    output logic             carry
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned WP1   = WIDTH + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - NIB);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_INC = 3'd1;
    localparam logic [2:0] OP_AOV = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd3;
    localparam logic [2:0] OP_ABS = 3'd4;
    localparam logic [2:0] OP_AAS = 3'd5;
    localparam logic [2:0] OP_BLT = 3'd6;
    localparam logic [2:0] OP_CON = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_e;

    state_e           state, state_d;
    logic [WIDTH-1:0] scan_word, scan_word_d;
    logic [NIB-1:0]   scan_pat, scan_pat_d;
    logic [IDX_W-1:0] scan_idx, scan_idx_d;
    logic             out_valid_d;
    logic [WIDTH-1:0] reg_out_d, stack0_out_d, stack1_out_d;
    logic             branch_sig_d, carry_d;

    logic             accept;
    logic [WIDTH:0]   add_sum, aov_sum;
    logic [WIDTH-1:0] abs_val, aas_t, aas_inv;
    logic             sh_big, blt_lt, win_hit;
    logic [NIB-1:0]   win;

    // Only one result slot: accept when idle and the slot is free or draining this edge.
    assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    // Datapath operands for the single-cycle ops.
    assign add_sum = {1'b0, stack0} + {1'b0, stack1};
    assign aov_sum = {1'b0, stack0} + {1'b0, reg_val} + WP1'(carry);
    assign abs_val = reg_val[WIDTH-1] ? (~reg_val) + WIDTH'(1) : reg_val;
    assign sh_big  = reg_val >= WIDTH'(WIDTH);
    assign aas_t   = (stack1 >> reg_val) & stack0;
    assign aas_inv = WIDTH'(WIDTH) - reg_val;
    assign blt_lt  = SIGNED_CMP ? ($signed(stack0) < $signed(stack1)) : (stack0 < stack1);

    // Current CON window, taken from the operands latched at accept.
    assign win     = NIB'(scan_word >> scan_idx);
    assign win_hit = (win == scan_pat);

    // Next-state and result logic.
    always_comb begin
        state_d      = state;
        scan_word_d  = scan_word;
        scan_pat_d   = scan_pat;
        scan_idx_d   = scan_idx;
        out_valid_d  = out_valid && !out_ready;
        reg_out_d    = reg_out;
        stack0_out_d = stack0_out;
        stack1_out_d = stack1_out;
        branch_sig_d = branch_sig;
        carry_d      = carry;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (op == OP_CON) begin
                        state_d     = ST_SCAN;
                        scan_word_d = stack0;
                        scan_pat_d  = stack1[NIB-1:0];
                        scan_idx_d  = '0;
                    end else begin
                        out_valid_d  = 1'b1;
                        reg_out_d    = '0;
                        stack0_out_d = '0;
                        stack1_out_d = '0;
                        branch_sig_d = 1'b0;
                        case (op)
                            OP_ADD: begin
                                reg_out_d = add_sum[WIDTH-1:0];
                                carry_d   = add_sum[WIDTH];
                            end
                            OP_INC: reg_out_d = reg_val + WIDTH'(1);
                            OP_AOV: begin
                                reg_out_d = aov_sum[WIDTH-1:0];
                                carry_d   = aov_sum[WIDTH];
                            end
                            OP_SUB: begin
                                reg_out_d = stack0 - stack1;
                                carry_d   = stack0 < stack1;
                            end
                            OP_ABS: begin
                                reg_out_d    = abs_val;
                                stack0_out_d = abs_val;
                            end
                            OP_AAS: begin
                                if (!sh_big) begin
                                    stack0_out_d = aas_t << reg_val;
                                    if (reg_val != '0) begin
                                        stack1_out_d = aas_t >> aas_inv;
                                    end
                                end
                            end
                            OP_BLT: branch_sig_d = blt_lt;
                            default: ;
                        endcase
                    end
                end
            end
            ST_SCAN: begin
                if (win_hit || scan_idx == LAST_IDX) begin
                    state_d      = ST_IDLE;
                    out_valid_d  = 1'b1;
                    stack0_out_d = '0;
                    stack1_out_d = '0;
                    branch_sig_d = win_hit;
                    reg_out_d    = win_hit ? WIDTH'(scan_idx) : '1;
                end else begin
                    scan_idx_d = scan_idx + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset abandons any scan in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            scan_word  <= '0;
            scan_pat   <= '0;
            scan_idx   <= '0;
            out_valid  <= 1'b0;
            reg_out    <= '0;
            stack0_out <= '0;
            stack1_out <= '0;
            branch_sig <= 1'b0;
            carry      <= 1'b0;
        end else begin
            state      <= state_d;
            scan_word  <= scan_word_d;
            scan_pat   <= scan_pat_d;
            scan_idx   <= scan_idx_d;
            out_valid  <= out_valid_d;
            reg_out    <= reg_out_d;
            stack0_out <= stack0_out_d;
            stack1_out <= stack1_out_d;
            branch_sig <= branch_sig_d;
            carry      <= carry_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: an unsigned-compare instance plus a signed-compare instance
// sharing the same stimulus.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [2:0] op;
    logic [7:0] reg_val, stack0, stack1;
    logic       out_ready;

    logic       in_ready, out_valid, branch_sig, carry;
    logic [7:0] reg_out, stack0_out, stack1_out;
    logic       s_in_ready, s_out_valid, s_branch_sig, s_carry;
    logic [7:0] s_reg_out, s_stack0_out, s_stack1_out;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(8), .NIB(4), .SIGNED_CMP(1'b0)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .reg_val(reg_val), .stack0(stack0), .stack1(stack1), .out_valid(out_valid),
        .out_ready(out_ready), .reg_out(reg_out), .stack0_out(stack0_out),
        .stack1_out(stack1_out), .branch_sig(branch_sig), .carry(carry)
    );

    alu_pipe #(.WIDTH(8), .NIB(4), .SIGNED_CMP(1'b1)) u_dut_s (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready), .op(op),
        .reg_val(reg_val), .stack0(stack0), .stack1(stack1), .out_valid(s_out_valid),
        .out_ready(out_ready), .reg_out(s_reg_out), .stack0_out(s_stack0_out),
        .stack1_out(s_stack1_out), .branch_sig(s_branch_sig), .carry(s_carry)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [7:0] r, input logic [7:0] a,
                         input logic [7:0] b);
        in_valid = 1'b1;
        op       = o;
        reg_val  = r;
        stack0   = a;
        stack1   = b;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; op = 3'd0; reg_val = 8'h00;
        stack0 = 8'h00; stack1 = 8'h00; out_ready = 1'b1;
        tick; tick;
        reset = 1'b0;
        #1;
        vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        vec++; if (carry !== 1'b0) begin miss++; $display("FAIL reset_carry got %b want 0", carry); end
        vec++; if (branch_sig !== 1'b0) begin miss++; $display("FAIL reset_branch got %b want 0", branch_sig); end
        vec++; if ({reg_out, stack0_out, stack1_out} !== 24'h0) begin miss++; $display("FAIL reset_data got %h want 000000", {reg_out, stack0_out, stack1_out}); end
        vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_aov;
        issue(3'd0, 8'h00, 8'hF0, 8'h20);
        tick;
        vec++; if (out_valid !== 1'b1) begin miss++; $display("FAIL add_valid got %b want 1", out_valid); end
        vec++; if (reg_out !== 8'h10) begin miss++; $display("FAIL add_reg got %h want 10", reg_out); end
        vec++; if (carry !== 1'b1) begin miss++; $display("FAIL add_carry got %b want 1", carry); end
        vec++; if (stack0_out !== 8'h00) begin miss++; $display("FAIL add_stack0 got %h want 00", stack0_out); end
        issue(3'd2, 8'h01, 8'h05, 8'hAA);
        tick;
        vec++; if (reg_out !== 8'h07) begin miss++; $display("FAIL aov_reg got %h want 07", reg_out); end
        vec++; if (carry !== 1'b0) begin miss++; $display("FAIL aov_carry got %b want 0", carry); end
        issue(3'd1, 8'hFF, 8'h00, 8'h00);
        tick;
        vec++; if (reg_out !== 8'h00) begin miss++; $display("FAIL inc_wrap_reg got %h want 00", reg_out); end
        vec++; if (carry !== 1'b0) begin miss++; $display("FAIL inc_wrap_carry got %b want 0", carry); end
        in_valid = 1'b0;
        tick;
        vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL consume_valid got %b want 0", out_valid); end
    endtask

    task automatic test_con(input logic [7:0] a, input logic [7:0] b, input logic exp_br,
                            input logic [7:0] exp_reg, input int exp_lat);
        int lat;
        issue(3'd7, 8'h00, a, b);
        tick;
        lat = 1;
        in_valid = 1'b0;
        stack0 = ~a;
        stack1 = ~b;
        while (!out_valid && lat < 20) begin
            vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL con_busy_in_ready got %b want 0 at lat %0d", in_ready, lat); end
            tick;
            lat++;
        end
        vec++; if (out_valid !== 1'b1) begin miss++; $display("FAIL con_timeout out_valid got %b want 1", out_valid); end
        vec++; if (lat !== exp_lat) begin miss++; $display("FAIL con_latency got %0d want %0d", lat, exp_lat); end
        vec++; if (branch_sig !== exp_br) begin miss++; $display("FAIL con_branch got %b want %b", branch_sig, exp_br); end
        vec++; if (reg_out !== exp_reg) begin miss++; $display("FAIL con_reg got %h want %h", reg_out, exp_reg); end
        vec++; if (carry !== 1'b0) begin miss++; $display("FAIL con_carry got %b want 0", carry); end
        tick;
        vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL con_consume got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        issue(3'd3, 8'h00, 8'h03, 8'h05);
        tick;
        vec++; if (reg_out !== 8'hFE) begin miss++; $display("FAIL sub_reg got %h want fe", reg_out); end
        vec++; if (carry !== 1'b1) begin miss++; $display("FAIL sub_borrow got %b want 1", carry); end
        issue(3'd1, 8'h41, 8'h00, 8'h00);
        #1;
        vec++; if (in_ready !== 1'b0) begin miss++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        tick; tick;
        vec++; if (reg_out !== 8'hFE || carry !== 1'b1 || out_valid !== 1'b1) begin
            miss++; $display("FAIL bp_hold got reg %h carry %b valid %b want fe 1 1", reg_out, carry, out_valid);
        end
        out_ready = 1'b1;
        #1;
        vec++; if (in_ready !== 1'b1) begin miss++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        tick;
        vec++; if (reg_out !== 8'h42) begin miss++; $display("FAIL bp_inc_reg got %h want 42", reg_out); end
        vec++; if (carry !== 1'b1 || out_valid !== 1'b1) begin miss++; $display("FAIL bp_inc_flags got carry %b valid %b want 1 1", carry, out_valid); end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_aas;
        issue(3'd5, 8'd2, 8'h3C, 8'hFF);
        tick;
        vec++; if ({reg_out, stack0_out, stack1_out} !== 24'h00F000) begin miss++; $display("FAIL aas_sh2 got %h want 00f000", {reg_out, stack0_out, stack1_out}); end
        issue(3'd5, 8'd9, 8'h3C, 8'hFF);
        tick;
        vec++; if ({reg_out, stack0_out, stack1_out} !== 24'h000000) begin miss++; $display("FAIL aas_sh9 got %h want 000000", {reg_out, stack0_out, stack1_out}); end
        issue(3'd5, 8'd0, 8'hF0, 8'h5A);
        tick;
        vec++; if ({reg_out, stack0_out, stack1_out} !== 24'h005000) begin miss++; $display("FAIL aas_sh0 got %h want 005000", {reg_out, stack0_out, stack1_out}); end
        issue(3'd5, 8'd6, 8'h03, 8'hC0);
        tick;
        vec++; if ({reg_out, stack0_out, stack1_out} !== 24'h00C000) begin miss++; $display("FAIL aas_sh6 got %h want 00c000", {reg_out, stack0_out, stack1_out}); end
    endtask

    task automatic test_abs;
        issue(3'd4, 8'hFB, 8'h77, 8'h77);
        tick;
        vec++; if ({reg_out, stack0_out, stack1_out} !== 24'h050500) begin miss++; $display("FAIL abs_neg got %h want 050500", {reg_out, stack0_out, stack1_out}); end
        issue(3'd4, 8'h80, 8'h00, 8'h00);
        tick;
        vec++; if ({reg_out, stack0_out} !== 16'h8080) begin miss++; $display("FAIL abs_min got %h want 8080", {reg_out, stack0_out}); end
        issue(3'd4, 8'h23, 8'h00, 8'h00);
        tick;
        vec++; if ({reg_out, stack0_out} !== 16'h2323) begin miss++; $display("FAIL abs_pos got %h want 2323", {reg_out, stack0_out}); end
    endtask

    task automatic test_blt;
        issue(3'd6, 8'h00, 8'h10, 8'h90);
        tick;
        vec++; if (branch_sig !== 1'b1) begin miss++; $display("FAIL blt_unsigned got %b want 1", branch_sig); end
        vec++; if (s_branch_sig !== 1'b0) begin miss++; $display("FAIL blt_signed got %b want 0", s_branch_sig); end
        vec++; if (reg_out !== 8'h00) begin miss++; $display("FAIL blt_reg got %h want 00", reg_out); end
        issue(3'd6, 8'h00, 8'h90, 8'h90);
        tick;
        vec++; if (branch_sig !== 1'b0 || s_branch_sig !== 1'b0) begin miss++; $display("FAIL blt_equal got %b/%b want 0/0", branch_sig, s_branch_sig); end
        issue(3'd6, 8'h00, 8'h90, 8'h10);
        tick;
        vec++; if (branch_sig !== 1'b0 || s_branch_sig !== 1'b1) begin miss++; $display("FAIL blt_neg_lt got %b/%b want 0/1", branch_sig, s_branch_sig); end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_scan;
        issue(3'd0, 8'h00, 8'hF0, 8'h20);
        tick;
        issue(3'd7, 8'h00, 8'h00, 8'h0F);
        tick;
        in_valid = 1'b0;
        tick; tick;
        vec++; if (in_ready !== 1'b0 || carry !== 1'b1) begin miss++; $display("FAIL mid_scan_pre got in_ready %b carry %b want 0 1", in_ready, carry); end
        reset = 1'b1;
        tick;
        reset = 1'b0;
        vec++; if (out_valid !== 1'b0 || carry !== 1'b0 || in_ready !== 1'b1) begin
            miss++; $display("FAIL mid_scan_reset got valid %b carry %b in_ready %b want 0 0 1", out_valid, carry, in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            tick;
            vec++; if (out_valid !== 1'b0) begin miss++; $display("FAIL mid_scan_stale got valid %b want 0 at cycle %0d", out_valid, i); end
        end
    endtask

    initial begin
        test_reset;
        test_add_aov;
        test_con(8'hB6, 8'h0D, 1'b1, 8'h02, 4);
        test_con(8'hB6, 8'h0F, 1'b0, 8'hFF, 6);
        test_con(8'h5A, 8'h0A, 1'b1, 8'h00, 2);
        test_backpressure;
        test_aas;
        test_abs;
        test_blt;
        test_reset_mid_scan;
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
